// File: rtl/cond_pkg.sv
// Shared types and constants for the condition unit: condition encodings,
// flag bit positions and the registered control payload.
package cond_pkg;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 0;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        MI = 4'b0100,
        PL = 4'b0101,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110
    } cond_t;

    typedef struct packed {
        logic cond_ex;
        logic pc_src;
        logic reg_write;
        logic mem_write;
    } ctrl_t;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit condition field against the {Z, N} flags.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [1:0] Flags,
    output logic       cond_true_c
);

    logic z;
    logic n;

    assign z = Flags[FLAG_Z];
    assign n = Flags[FLAG_N];

    // Unlisted encodings mean "never".
    always_comb begin
        cond_true_c = 1'b0;
        case (cond_t'(Cond))
            EQ:      cond_true_c = z;
            NE:      cond_true_c = !z;
            MI:      cond_true_c = n;
            PL:      cond_true_c = !n;
            GE:      cond_true_c = !n;
            LT:      cond_true_c = n;
            GT:      cond_true_c = !z && !n;
            LE:      cond_true_c = z || n;
            AL:      cond_true_c = 1'b1;
            default: cond_true_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: architectural flags, condition gating of write/branch
// controls into the EX/MEM boundary, and saturating debug counters.
module cond_unit
    import cond_pkg::*;
#(
    parameter int unsigned N = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Valid,
    input  logic [3:0]   Cond,
    input  logic [1:0]   ALUFlags,
    input  logic         FlagW,
    input  logic         PCS,
    input  logic         RegW,
    input  logic         MemW,
    input  logic         Stall,
    input  logic         Flush,
    output logic         CondEx,
    output logic         PCSrc,
    output logic         RegWrite,
    output logic         MemWrite,
    output logic [1:0]   Flags,
    output logic [N-1:0] ExecCount,
    output logic [N-1:0] SkipCount
);

    localparam logic [N-1:0] CNT_MAX = '1;

    logic         cond_true_c;
    logic         pass_c;
    logic         fail_c;

    ctrl_t        ctrl_q,  ctrl_d;
    logic [1:0]   flags_q, flags_d;
    logic [N-1:0] exec_q,  exec_d;
    logic [N-1:0] skip_q,  skip_d;

    // Condition is checked against the registered flags, never ALUFlags.
    cond_check u_cond_check (
        .Cond        (Cond),
        .Flags       (flags_q),
        .cond_true_c (cond_true_c)
    );

    assign pass_c = Valid && !Flush && cond_true_c;
    assign fail_c = Valid && !Flush && !cond_true_c;

    // Flush beats Stall; a flushed slot clears the controls but touches no state.
    always_comb begin
        ctrl_d  = ctrl_q;
        flags_d = flags_q;
        exec_d  = exec_q;
        skip_d  = skip_q;
        if (Flush) begin
            ctrl_d = '0;
        end else if (!Stall) begin
            ctrl_d.cond_ex   = pass_c;
            ctrl_d.pc_src    = PCS  && pass_c;
            ctrl_d.reg_write = RegW && pass_c;
            ctrl_d.mem_write = MemW && pass_c;
            if (pass_c && FlagW) begin
                flags_d = ALUFlags;
            end
            if (pass_c && (exec_q != CNT_MAX)) begin
                exec_d = exec_q + N'(1);
            end
            if (fail_c && (skip_q != CNT_MAX)) begin
                skip_d = skip_q + N'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= '0;
            flags_q <= '0;
            exec_q  <= '0;
            skip_q  <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            flags_q <= flags_d;
            exec_q  <= exec_d;
            skip_q  <= skip_d;
        end
    end

    assign CondEx    = ctrl_q.cond_ex;
    assign PCSrc     = ctrl_q.pc_src;
    assign RegWrite  = ctrl_q.reg_write;
    assign MemWrite  = ctrl_q.mem_write;
    assign Flags     = flags_q;
    assign ExecCount = exec_q;
    assign SkipCount = skip_q;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed vector table, condition sweep,
// saturation run and randomized traffic against a behavioural model.
module tb_cond_unit;

    localparam int unsigned NW  = 4;
    localparam int          SAT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          Valid;
    logic [3:0]    Cond;
    logic [1:0]    ALUFlags;
    logic          FlagW;
    logic          PCS;
    logic          RegW;
    logic          MemW;
    logic          Stall;
    logic          Flush;
    logic          CondEx;
    logic          PCSrc;
    logic          RegWrite;
    logic          MemWrite;
    logic [1:0]    Flags;
    logic [NW-1:0] ExecCount;
    logic [NW-1:0] SkipCount;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] m_ctrl;
    logic [1:0] m_flags;
    int         m_exec;
    int         m_skip;

    typedef struct {
        logic       valid, flush, stall, flagw, pcs, regw, memw;
        logic [3:0] cond;
        logic [1:0] alu;
        logic [3:0] e_ctrl;
        logic [1:0] e_flags;
        logic [3:0] e_exec;
        logic [3:0] e_skip;
    } vec_t;

    vec_t vq[$];

    cond_unit #(.N(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .Valid     (Valid),
        .Cond      (Cond),
        .ALUFlags  (ALUFlags),
        .FlagW     (FlagW),
        .PCS       (PCS),
        .RegW      (RegW),
        .MemW      (MemW),
        .Stall     (Stall),
        .Flush     (Flush),
        .CondEx    (CondEx),
        .PCSrc     (PCSrc),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .Flags     (Flags),
        .ExecCount (ExecCount),
        .SkipCount (SkipCount)
    );

    always #5 clk = ~clk;

    // Truth of each condition mnemonic for flags {Z, N}.
    function automatic logic cond_ref(input logic [3:0] c, input logic [1:0] f);
        logic z;
        logic n;
        z = f[1];
        n = f[0];
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd4:    return n;
            4'd5:    return !n;
            4'd10:   return !n;
            4'd11:   return n;
            4'd12:   return !z && !n;
            4'd13:   return z || n;
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat_inc(input int v);
        return (v < SAT) ? v + 1 : SAT;
    endfunction

    // Architectural effect of one clock edge given the current inputs.
    task automatic model_step();
        logic ct;
        logic pass;
        if (rst) begin
            m_ctrl  = '0;
            m_flags = '0;
            m_exec  = 0;
            m_skip  = 0;
        end else if (Flush) begin
            m_ctrl = '0;
        end else if (!Stall) begin
            ct     = cond_ref(Cond, m_flags);
            pass   = Valid && ct;
            m_ctrl = {pass, PCS && pass, RegW && pass, MemW && pass};
            if (pass && FlagW) m_flags = ALUFlags;
            if (pass) m_exec = sat_inc(m_exec);
            if (Valid && !ct) m_skip = sat_inc(m_skip);
        end
    endtask

    function automatic logic [13:0] dut_vec();
        return {CondEx, PCSrc, RegWrite, MemWrite, Flags, ExecCount, SkipCount};
    endfunction

    function automatic logic [13:0] model_vec();
        return {m_ctrl, m_flags, 4'(m_exec), 4'(m_skip)};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic fl, input logic st, input logic [3:0] c,
                         input logic [1:0] alu, input logic fw, input logic pcs,
                         input logic rw, input logic mw);
        Valid    = v;
        Flush    = fl;
        Stall    = st;
        Cond     = c;
        ALUFlags = alu;
        FlagW    = fw;
        PCS      = pcs;
        RegW     = rw;
        MemW     = mw;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 4'he, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        check("reset_clear", 16'(dut_vec()), 16'h0);
    endtask

    task automatic add_row(input logic v, input logic fl, input logic st, input logic [3:0] c,
                           input logic [1:0] alu, input logic fw, input logic pcs,
                           input logic rw, input logic mw, input logic [3:0] ec,
                           input logic [1:0] ef, input logic [3:0] ex, input logic [3:0] es);
        vec_t r;
        r.valid = v;  r.flush = fl; r.stall = st; r.cond = c; r.alu = alu;
        r.flagw = fw; r.pcs = pcs;  r.regw = rw;  r.memw = mw;
        r.e_ctrl = ec; r.e_flags = ef; r.e_exec = ex; r.e_skip = es;
        vq.push_back(r);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Expected ctrl is {CondEx, PCSrc, RegWrite, MemWrite}.
        //      v  fl st cond   alu    fw pcs rw mw   ctrl     flags  exec skip
        add_row(1, 0, 0, 4'he, 2'b10, 1, 0, 0, 0, 4'b1000, 2'b10, 4'd1, 4'd0);
        add_row(1, 0, 0, 4'h0, 2'b00, 0, 0, 1, 0, 4'b1010, 2'b10, 4'd2, 4'd0);
        add_row(1, 0, 0, 4'h1, 2'b00, 0, 0, 0, 1, 4'b0000, 2'b10, 4'd2, 4'd1);
        add_row(0, 0, 0, 4'he, 2'b00, 0, 0, 1, 0, 4'b0000, 2'b10, 4'd2, 4'd1);
        add_row(1, 0, 0, 4'he, 2'b00, 1, 1, 0, 0, 4'b1100, 2'b00, 4'd3, 4'd1);
        add_row(1, 0, 0, 4'h0, 2'b10, 1, 0, 0, 0, 4'b0000, 2'b00, 4'd3, 4'd2);
        add_row(1, 0, 0, 4'he, 2'b00, 0, 0, 0, 1, 4'b1001, 2'b00, 4'd4, 4'd2);
        add_row(1, 0, 1, 4'he, 2'b01, 1, 0, 0, 1, 4'b1001, 2'b00, 4'd4, 4'd2);
        add_row(1, 1, 1, 4'he, 2'b01, 1, 0, 0, 1, 4'b0000, 2'b00, 4'd4, 4'd2);
        add_row(1, 1, 0, 4'he, 2'b01, 1, 0, 1, 0, 4'b0000, 2'b00, 4'd4, 4'd2);
        add_row(1, 0, 0, 4'hb, 2'b00, 0, 0, 1, 0, 4'b0000, 2'b00, 4'd4, 4'd3);
        add_row(1, 0, 0, 4'hc, 2'b00, 0, 1, 0, 0, 4'b1100, 2'b00, 4'd5, 4'd3);

        // Reset held two cycles under Stall with an instruction in flight.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 4'he, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check("reset_edge1", 16'(dut_vec()), 16'h0);
        tick();
        check("reset_edge2", 16'(dut_vec()), 16'h0);
        rst = 1'b0;

        foreach (vq[i]) begin
            drive(vq[i].valid, vq[i].flush, vq[i].stall, vq[i].cond, vq[i].alu,
                  vq[i].flagw, vq[i].pcs, vq[i].regw, vq[i].memw);
            tick();
            check($sformatf("table_row%0d", i), 16'(dut_vec()),
                  16'({vq[i].e_ctrl, vq[i].e_flags, vq[i].e_exec, vq[i].e_skip}));
        end

        // Reset from a non-zero state, overriding a concurrent Flush.
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 4'he, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        check("reset_nonzero", 16'(dut_vec()), 16'h0);

        // Own-flags: a flag-setting EQ evaluates against the old Z=0.
        drive(1'b1, 1'b0, 1'b0, 4'h0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("own_flags_flags", 16'(Flags), 16'h0);
        check("own_flags_skip", 16'(SkipCount), 16'h1);
        check("own_flags_condex", 16'(CondEx), 16'h0);

        // Every condition code against each reachable flag value.
        for (int f = 0; f < 3; f++) begin
            do_reset();
            drive(1'b1, 1'b0, 1'b0, 4'he, 2'(f), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            check("sweep_setflags", 16'(Flags), 16'(f));
            for (int c = 0; c < 16; c++) begin
                drive(1'b1, 1'b0, 1'b0, 4'(c), 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
                tick();
                check($sformatf("sweep_f%0d_c%0d", f, c), 16'(CondEx),
                      16'(cond_ref(4'(c), 2'(f))));
                check($sformatf("sweep_state_f%0d_c%0d", f, c), 16'(dut_vec()),
                      16'(model_vec()));
            end
        end

        // Saturation of ExecCount at 15.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b0, 1'b0, 4'he, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            check($sformatf("sat_step%0d", k), 16'(ExecCount), 16'((k + 1 < SAT) ? k + 1 : SAT));
        end
        check("sat_final", 16'(ExecCount), 16'd15);

        // Randomized traffic against the model, including occasional resets.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            tick();
            check($sformatf("random_cyc%0d", k), 16'(dut_vec()), 16'(model_vec()));
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
# cond_unit

Condition unit that consumes the ALU's two-bit flag output. It holds the architectural flag register and evaluates each instruction's 4-bit condition field against it. It then gates the instruction's write and branch controls, and registers the result into the execute/memory pipeline boundary. It also keeps saturating counts of executed and squashed instructions for debug.

## Interface
- N, 16: width of the ExecCount and SkipCount counters.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- Valid  in  1  an instruction is present this cycle.
- Cond  in  4  condition field of the current instruction.
- ALUFlags  in  2  flags for the current instruction: {Zero, Neg}, bit 1 = Zero, bit 0 = Neg.
- FlagW  in  1  the instruction requests a flag update.
- PCS  in  1  the instruction requests a branch.
- RegW  in  1  the instruction requests a register write.
- MemW  in  1  the instruction requests a memory write.
- Stall  in  1  hold all state this cycle.
- Flush  in  1  squash the current instruction.
- CondEx  out  1  registered: the condition passed.
- PCSrc  out  1  registered: PCS gated by the condition.
- RegWrite  out  1  registered: RegW gated by the condition.
- MemWrite  out  1  registered: MemW gated by the condition.
- Flags  out  2  architectural flag register {Z, N}.
- ExecCount  out  N  count of executed instructions, saturating.
- SkipCount  out  N  count of condition-failed instructions, saturating.

## Operation
- Condition evaluation is combinational and uses the registered Flags, not ALUFlags. Encodings:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0100 MI: N
  - 0101 PL: !N
  - 1010 GE: !N
  - 1011 LT: N
  - 1100 GT: !Z & !N
  - 1101 LE: Z | N
  - 1110 AL: 1
  - every other code: 0 (never)
- Definition: pass = Valid & !Flush & cond_true.
- Flag update: Flags <= ALUFlags at the edge when pass & FlagW & !Stall. Otherwise Flags holds.
- Output register, on an edge with !Stall:
  - CondEx <= pass
  - PCSrc <= PCS & pass
  - RegWrite <= RegW & pass
  - MemWrite <= MemW & pass
- Counters, on an edge with !Stall:
  - ExecCount increments when pass.
  - SkipCount increments when Valid & !Flush & !cond_true.
  - Both saturate at 2^N-1 and never wrap.
  - A flushed instruction counts in neither counter.
- Stall: all registers hold, including Flags and both counters.
- Stall and Flush together: Flush wins.
  - Output registers are cleared to 0.
  - Flags and the counters hold.
- Reset: all outputs go to 0 at the first edge with rst=1.
  - This covers CondEx, PCSrc, RegWrite, MemWrite, Flags, ExecCount and SkipCount.
  - rst overrides Stall and Flush.
  - An instruction in flight during reset is discarded and is not counted.
- Valid=0: the cycle is treated as a bubble. Outputs load 0, and Flags and the counters hold.

## Timing
- Latency is one cycle from Cond/Valid to CondEx, PCSrc, RegWrite and MemWrite.
- Flags written at edge k are visible to the condition check in cycle k+1. Back-to-back flag-set then conditional needs no bubble.
- The flag-setting instruction itself evaluates against the old Flags.
- No combinational path exists from any input to any output.

## Structure
- Package cond_pkg holds:
  - cond_t enum: EQ, NE, MI, PL, GE, LT, GT, LE, AL.
  - Flag index constants: FLAG_Z=1, FLAG_N=0.
  - Counter width default.
- Sub-module cond_check is purely combinational: (Cond, Flags) -> cond_true. It is instantiated once inside cond_unit.
- The registers, counters and stall/flush priority stay in cond_unit.

## Test plan
- Reset: assert rst for 2 cycles with Stall=1, Flush=0 -> all outputs 0 after the first edge; counters stay 0.
- Flag chain:
  - Cycle 1: AL, FlagW=1, ALUFlags=2'b10.
  - Cycle 2: EQ with RegW=1.
  - Required: Flags=2'b10 after cycle 1; CondEx=1 and RegWrite=1 one cycle after cycle 2; ExecCount=2.
- Own-flags check: with Flags=2'b00, present EQ, FlagW=1, ALUFlags=2'b10 -> condition fails, Flags stay 2'b00, SkipCount increments to 1.
- All condition codes: sweep every Cond code against each Flags value 00, 01, 10 -> CondEx matches the encoding list above. Codes 0010, 0011, 0110–1001 and 1111 always give 0.
- Stall/Flush priority:
  - Stall=1 with a passing MemW instruction -> outputs and counters frozen.
  - Then Stall=1 and Flush=1 -> MemWrite=0 next cycle, Flags unchanged, counters unchanged.
- Saturation: with N=4, issue 20 passing AL instructions -> ExecCount reaches 15 and holds at 15.
